// File: rtl/z80_bus_pkg.sv
// Shared types for the Z80 bus responder: cycle kinds, FSM states, trace codes
// and the saturating wait-count helper.
package z80_bus_pkg;

   localparam int WAIT_CNT_BITS = 4;
   localparam int WAIT_CNT_MAX  = (1 << WAIT_CNT_BITS) - 1;

   typedef enum logic [1:0] {
      KIND_MEM  = 2'd0,
      KIND_IO   = 2'd1,
      KIND_INTA = 2'd2
   } cycle_kind_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_ACCESS = 2'd2,
      ST_HOLD   = 2'd3
   } bus_state_e;

   localparam logic [1:0] TRC_MEM_RD = 2'd0;
   localparam logic [1:0] TRC_MEM_WR = 2'd1;
   localparam logic [1:0] TRC_IO     = 2'd2;
   localparam logic [1:0] TRC_INTA   = 2'd3;

   // MEM_WAIT + M1_WAIT can exceed the counter range; clamp instead of wrapping.
   function automatic logic [WAIT_CNT_BITS-1:0] wait_sum(input int a, input int b);
      int s;
      s = a + b;
      if (s > WAIT_CNT_MAX) s = WAIT_CNT_MAX;
      if (s < 0) s = 0;
      return WAIT_CNT_BITS'(s);
   endfunction

endpackage

// File: rtl/z80_bus_wait_gen.sv
// Wait-state generator: loads a count at cycle start, holds WAIT_n low for
// exactly that many clocks, and flags the final wait clock.
module z80_bus_wait_gen
   import z80_bus_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     load,
   input  logic [WAIT_CNT_BITS-1:0] load_val,
   output logic                     wait_n,
   output logic                     done
);

   logic [WAIT_CNT_BITS-1:0] cnt_q, cnt_d;
   logic                     wait_n_q, wait_n_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = load_val;
      else if (cnt_q != '0)
         cnt_d = cnt_q - 1'b1;
      wait_n_d = (cnt_d == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         wait_n_q <= 1'b1;
      end else begin
         cnt_q    <= cnt_d;
         wait_n_q <= wait_n_d;
      end
   end

   assign wait_n = wait_n_q;
   assign done   = !load && (cnt_q == WAIT_CNT_BITS'(1));

endmodule

// File: rtl/z80_bus_responder.sv
// Z80/R800 bus target: loadable memory, I/O bank, wait-state insertion and
// INTA vector. Define BUS_TRACE_EN to add the per-cycle trace output port group.
module z80_bus_responder
   import z80_bus_pkg::*;
#(
   parameter int         ADDR_BITS  = 8,
   parameter int         IO_BITS    = 4,
   parameter int         MEM_WAIT   = 0,
   parameter int         M1_WAIT    = 1,
   parameter int         IO_WAIT    = 1,
   parameter logic [7:0] INT_VECTOR = 8'hFF
) (
   input  logic                 CLK_n,
   input  logic                 RESET_n,
   input  logic [15:0]          A,
   input  logic                 M1_n,
   input  logic                 MREQ_n,
   input  logic                 IORQ_n,
   input  logic                 RD_n,
   input  logic                 WR_n,
   input  logic                 RFSH_n,
   input  logic [7:0]           d_in,
   output logic [7:0]           d_out,
   output logic                 d_oe,
   output logic                 WAIT_n,
   input  logic                 ld_en,
   input  logic [ADDR_BITS-1:0] ld_addr,
   input  logic [7:0]           ld_data
`ifdef BUS_TRACE_EN
   ,
   output logic                 trace_valid,
   output logic [1:0]           trace_kind,
   output logic                 trace_m1,
   output logic [15:0]          trace_addr,
   output logic [7:0]           trace_data
`endif
);

   logic [7:0] mem [2**ADDR_BITS];
   logic [7:0] io  [2**IO_BITS];

   bus_state_e  state_q, state_d;
   cycle_kind_e kind_q, kind_d;
   logic [15:0] addr_q, addr_d;
   logic        m1_q, m1_d;
   logic [7:0]  d_out_q, d_out_d;
   logic        wr_done_q, wr_done_d;

   logic                     req;
   cycle_kind_e              req_kind;
   logic                     start;
   logic [WAIT_CNT_BITS-1:0] load_val;
   logic                     wg_done;
   logic                     wr_fire, mem_we, io_we;
   logic [7:0]               rd_byte;

   // Refresh (MREQ_n with RFSH_n low) is not a memory request; MEM beats IO.
   always_comb begin
      req      = 1'b0;
      req_kind = KIND_MEM;
      if (!MREQ_n && RFSH_n) begin
         req      = 1'b1;
         req_kind = KIND_MEM;
      end else if (!IORQ_n) begin
         req      = 1'b1;
         req_kind = M1_n ? KIND_IO : KIND_INTA;
      end
      start = (state_q == ST_IDLE) && req;

      case (req_kind)
         KIND_MEM: load_val = wait_sum(MEM_WAIT, M1_n ? 0 : M1_WAIT);
         default:  load_val = wait_sum(IO_WAIT, 0);
      endcase

      case (req_kind)
         KIND_MEM: rd_byte = mem[A[ADDR_BITS-1:0]];
         KIND_IO:  rd_byte = io[A[IO_BITS-1:0]];
         default:  rd_byte = INT_VECTOR;
      endcase
   end

   // One write per cycle: the first WR_n low seen in ACCESS or HOLD.
   assign wr_fire = ((state_q == ST_ACCESS) || (state_q == ST_HOLD)) && !WR_n &&
                    !wr_done_q && (kind_q != KIND_INTA);
   assign mem_we  = wr_fire && (kind_q == KIND_MEM);
   assign io_we   = wr_fire && (kind_q == KIND_IO);

   always_comb begin
      state_d   = state_q;
      kind_d    = kind_q;
      addr_d    = addr_q;
      m1_d      = m1_q;
      d_out_d   = d_out_q;
      wr_done_d = wr_done_q || wr_fire;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               addr_d    = A;
               kind_d    = req_kind;
               m1_d      = !M1_n;
               d_out_d   = rd_byte;
               wr_done_d = 1'b0;
               state_d   = (load_val != '0) ? ST_WAIT : ST_ACCESS;
            end
         end
         ST_WAIT:   if (wg_done) state_d = ST_ACCESS;
         ST_ACCESS: state_d = ST_HOLD;
         ST_HOLD:   if (MREQ_n && IORQ_n) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK_n or negedge RESET_n) begin
      if (!RESET_n) begin
         state_q   <= ST_IDLE;
         kind_q    <= KIND_MEM;
         addr_q    <= '0;
         m1_q      <= 1'b0;
         d_out_q   <= 8'h00;
         wr_done_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         kind_q    <= kind_d;
         addr_q    <= addr_d;
         m1_q      <= m1_d;
         d_out_q   <= d_out_d;
         wr_done_q <= wr_done_d;
      end
   end

   z80_bus_wait_gen u_wait_gen (
      .clk      (CLK_n),
      .rst_n    (RESET_n),
      .load     (start),
      .load_val (load_val),
      .wait_n   (WAIT_n),
      .done     (wg_done)
   );

   // Storage is deliberately not reset; preload wins a same-address collision.
   always_ff @(posedge CLK_n) begin
      if (mem_we && !(ld_en && (ld_addr == addr_q[ADDR_BITS-1:0])))
         mem[addr_q[ADDR_BITS-1:0]] <= d_in;
      if (ld_en)
         mem[ld_addr] <= ld_data;
   end

   always_ff @(posedge CLK_n) begin
      if (io_we)
         io[addr_q[IO_BITS-1:0]] <= d_in;
   end

   assign d_out = d_out_q;
   assign d_oe  = (state_q != ST_IDLE) && WR_n && (!RD_n || (kind_q == KIND_INTA));

`ifdef BUS_TRACE_EN
   logic        trc_valid_q, trc_valid_d;
   logic [1:0]  trc_kind_q, trc_kind_d;
   logic        trc_m1_q, trc_m1_d;
   logic [15:0] trc_addr_q, trc_addr_d;
   logic [7:0]  trc_data_q, trc_data_d;
   logic [7:0]  wdata_q, wdata_d;
   logic        wrote;

   always_comb begin
      wrote       = wr_done_q || wr_fire;
      wdata_d     = wr_fire ? d_in : wdata_q;
      trc_valid_d = (state_q == ST_HOLD) && MREQ_n && IORQ_n;
      trc_kind_d  = trc_kind_q;
      trc_m1_d    = trc_m1_q;
      trc_addr_d  = trc_addr_q;
      trc_data_d  = trc_data_q;
      if (trc_valid_d) begin
         case (kind_q)
            KIND_MEM: trc_kind_d = wrote ? TRC_MEM_WR : TRC_MEM_RD;
            KIND_IO:  trc_kind_d = TRC_IO;
            default:  trc_kind_d = TRC_INTA;
         endcase
         trc_m1_d   = m1_q;
         trc_addr_d = addr_q;
         trc_data_d = wr_fire ? d_in : (wr_done_q ? wdata_q : d_out_q);
      end
   end

   always_ff @(posedge CLK_n or negedge RESET_n) begin
      if (!RESET_n) begin
         trc_valid_q <= 1'b0;
         trc_kind_q  <= 2'd0;
         trc_m1_q    <= 1'b0;
         trc_addr_q  <= '0;
         trc_data_q  <= '0;
         wdata_q     <= '0;
      end else begin
         trc_valid_q <= trc_valid_d;
         trc_kind_q  <= trc_kind_d;
         trc_m1_q    <= trc_m1_d;
         trc_addr_q  <= trc_addr_d;
         trc_data_q  <= trc_data_d;
         wdata_q     <= wdata_d;
      end
   end

   assign trace_valid = trc_valid_q;
   assign trace_kind  = trc_kind_q;
   assign trace_m1    = trc_m1_q;
   assign trace_addr  = trc_addr_q;
   assign trace_data  = trc_data_q;
`else
   // Latched fields only the trace port consumes.
   logic unused_trace_sig;
   assign unused_trace_sig = ^{addr_q, m1_q};
`endif

endmodule

// File: tb/tb_z80_bus_responder.sv
// Scoreboard bench for z80_bus_responder: emulates T800 bus cycles (fetch,
// read, write, I/O, INTA, refresh, reset abort) and checks data, d_oe and waits.
module tb_z80_bus_responder;

   localparam int OP_MEMRD = 0, OP_MEMWR = 1, OP_IORD = 2, OP_IOWR = 3, OP_INTA = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] a;
   logic        m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n;
   logic [7:0]  d_in, d_out;
   logic        d_oe, wait_n;
   logic        ld_en;
   logic [7:0]  ld_addr, ld_data;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int         op;
      logic [7:0] data;
      int         waits;
   } exp_t;
   exp_t exp_q[$];

`ifdef BUS_TRACE_EN
   logic        trace_valid, trace_m1;
   logic [1:0]  trace_kind;
   logic [15:0] trace_addr;
   logic [7:0]  trace_data;
   int          trace_cnt = 0;
   always @(negedge clk) if (trace_valid) trace_cnt++;
`endif

   z80_bus_responder #(
      .ADDR_BITS(8), .IO_BITS(4), .MEM_WAIT(2), .M1_WAIT(1), .IO_WAIT(1),
      .INT_VECTOR(8'hCF)
   ) dut (
      .CLK_n(clk), .RESET_n(rst_n), .A(a), .M1_n(m1_n), .MREQ_n(mreq_n),
      .IORQ_n(iorq_n), .RD_n(rd_n), .WR_n(wr_n), .RFSH_n(rfsh_n),
      .d_in(d_in), .d_out(d_out), .d_oe(d_oe), .WAIT_n(wait_n),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
`ifdef BUS_TRACE_EN
      , .trace_valid(trace_valid), .trace_kind(trace_kind), .trace_m1(trace_m1),
      .trace_addr(trace_addr), .trace_data(trace_data)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic idle_bus();
      mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1; rfsh_n = 1'b1;
   endtask

   task automatic preload(input logic [7:0] ad, input logic [7:0] dt);
      @(negedge clk);
      ld_en = 1'b1; ld_addr = ad; ld_data = dt;
      @(negedge clk);
      ld_en = 1'b0;
   endtask

   // One bus cycle; expectation pushed at drive time, popped once WAIT_n releases.
   task automatic cyc(input int op, input logic [15:0] ad, input logic m1,
                      input logic [7:0] dt, input int waits, input int hold,
                      input bit late, input bit ld_hit);
      int   n;
      exp_t e;
      @(negedge clk);
      a = ad; d_in = dt;
      exp_q.push_back('{op: op, data: dt, waits: waits});
      case (op)
         OP_MEMRD: begin mreq_n = 1'b0; rd_n = 1'b0; m1_n = ~m1; end
         OP_MEMWR: begin mreq_n = 1'b0; wr_n = late; end
         OP_IORD:  begin iorq_n = 1'b0; rd_n = 1'b0; end
         OP_IOWR:  begin iorq_n = 1'b0; wr_n = late; end
         default:  begin iorq_n = 1'b0; m1_n = 1'b0; d_in = 8'h77; end
      endcase
      n = 0;
      @(negedge clk);
      while (!wait_n && n < 40) begin
         n++;
         @(negedge clk);
      end
      if (n >= 40) chk($sformatf("wait_timeout@%h", ad), 32'd1, 32'd0);
      e = exp_q.pop_front();
      chk($sformatf("waits@%h", ad), n, e.waits);
      if (e.op == OP_MEMWR || e.op == OP_IOWR) begin
         chk($sformatf("wr_doe@%h", ad), {31'd0, d_oe}, 32'd0);
         if (ld_hit) begin ld_en = 1'b1; ld_addr = ad[7:0]; ld_data = 8'h42; end
         if (late) begin @(negedge clk); wr_n = 1'b0; end
         @(negedge clk);
         d_in = ~e.data; ld_en = 1'b0;
         repeat (hold - 1) @(negedge clk);
      end else begin
         chk($sformatf("rd_doe@%h", ad), {31'd0, d_oe}, 32'd1);
         chk($sformatf("rd_data@%h", ad), {24'd0, d_out}, {24'd0, e.data});
         @(negedge clk);
      end
      idle_bus();
   endtask

   task automatic refresh(input logic [15:0] ad);
      @(negedge clk);
      a = ad; mreq_n = 1'b0; rfsh_n = 1'b0; rd_n = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("rfsh_wait_n", {31'd0, wait_n}, 32'd1);
         chk("rfsh_doe", {31'd0, d_oe}, 32'd0);
      end
      idle_bus();
   endtask

   initial begin
      int tc0;
      rst_n = 1'b0; a = '0; d_in = '0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
      idle_bus();
      rd_n = 1'b0;
      preload(8'h00, 8'hDD); preload(8'h01, 8'h21); preload(8'h02, 8'h23);
      preload(8'h03, 8'h34); preload(8'h04, 8'h21); preload(8'h05, 8'h45);
      preload(8'h06, 8'h56); preload(8'h07, 8'hE7); preload(8'h50, 8'h11);
      #1;
      chk("rst_wait_n", {31'd0, wait_n}, 32'd1);
      chk("rst_doe", {31'd0, d_oe}, 32'd0);
      chk("rst_dout", {24'd0, d_out}, 32'd0);
      @(negedge clk);
      rd_n = 1'b1; rst_n = 1'b1;

      // LD IX,3423h ; LD HL,5645h
      cyc(OP_MEMRD, 16'h0000, 1'b1, 8'hDD, 3, 1, 0, 0); refresh(16'h0000);
      cyc(OP_MEMRD, 16'h0001, 1'b1, 8'h21, 3, 1, 0, 0); refresh(16'h0001);
      cyc(OP_MEMRD, 16'h0002, 1'b0, 8'h23, 2, 1, 0, 0);
      cyc(OP_MEMRD, 16'h0003, 1'b0, 8'h34, 2, 1, 0, 0);
      cyc(OP_MEMRD, 16'h0004, 1'b1, 8'h21, 3, 1, 0, 0); refresh(16'h0002);
      cyc(OP_MEMRD, 16'h0005, 1'b0, 8'h45, 2, 1, 0, 0);
      cyc(OP_MEMRD, 16'h0006, 1'b0, 8'h56, 2, 1, 0, 0);

      // Write held 3 clocks with changing data, late write, aliasing
      cyc(OP_MEMWR, 16'h0040, 1'b0, 8'hA5, 2, 3, 0, 0);
      cyc(OP_MEMRD, 16'h0040, 1'b0, 8'hA5, 2, 1, 0, 0);
      cyc(OP_MEMWR, 16'h0041, 1'b0, 8'h3C, 2, 2, 1, 0);
      cyc(OP_MEMRD, 16'h0041, 1'b0, 8'h3C, 2, 1, 0, 0);
      cyc(OP_MEMRD, 16'h0140, 1'b0, 8'hA5, 2, 1, 0, 0);

      // I/O write/read, memory untouched; INTA vector writes nothing
      cyc(OP_IOWR, 16'h0007, 1'b0, 8'h5A, 1, 1, 0, 0);
      cyc(OP_IORD, 16'h0007, 1'b0, 8'h5A, 1, 1, 0, 0);
      cyc(OP_MEMRD, 16'h0007, 1'b0, 8'hE7, 2, 1, 0, 0);
      cyc(OP_INTA, 16'h0007, 1'b1, 8'hCF, 1, 1, 0, 0);
      cyc(OP_IORD, 16'h0007, 1'b0, 8'h5A, 1, 1, 0, 0);

      // Preload beats a CPU write to the same address in the same clock
      cyc(OP_MEMWR, 16'h0060, 1'b0, 8'h99, 2, 1, 0, 1);
      cyc(OP_MEMRD, 16'h0060, 1'b0, 8'h42, 2, 1, 0, 0);

      // Reset during WAIT of a write, then during a read
`ifdef BUS_TRACE_EN
      tc0 = trace_cnt;
`else
      tc0 = 0;
`endif
      @(negedge clk);
      a = 16'h0050; d_in = 8'h99; mreq_n = 1'b0; wr_n = 1'b0;
      @(negedge clk);
      chk("abort_pre_wait_n", {31'd0, wait_n}, 32'd0);
      rst_n = 1'b0;
      #1;
      chk("abort_wait_n", {31'd0, wait_n}, 32'd1);
      chk("abort_doe", {31'd0, d_oe}, 32'd0);
      @(negedge clk);
      idle_bus(); rst_n = 1'b1;
      @(negedge clk);
      a = 16'h0050; mreq_n = 1'b0; rd_n = 1'b0;
      @(negedge clk);
      chk("abort_rd_pre_doe", {31'd0, d_oe}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_rd_doe", {31'd0, d_oe}, 32'd0);
      @(negedge clk);
      idle_bus(); rst_n = 1'b1;
      cyc(OP_MEMRD, 16'h0050, 1'b0, 8'h11, 2, 1, 0, 0);
      repeat (2) @(negedge clk);
`ifdef BUS_TRACE_EN
      chk("trace_abort_pulses", trace_cnt - tc0, 32'd1);
      chk("trace_last_kind", {30'd0, trace_kind}, 32'd0);
      chk("trace_last_data", {24'd0, trace_data}, 32'h11);
`else
      chk("abort_tc0", tc0, 32'd0);
`endif
      chk("scoreboard_empty", exp_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/z80_bus_responder.md
Name: z80_bus_responder

Overview:
- Parametrised, synthesizable Z80/R800 bus-side target for the T800 core.
- Replaces the fixed 16-byte A[3:0] opcode table with:
  - a loadable memory of parameterised depth;
  - a separate I/O register bank;
  - per-cycle-type wait-state insertion via WAIT_n;
  - interrupt-acknowledge vector response.
- Used in simulation benches and as an on-chip boot RAM/IO stub beside the CPU core.

Parameters:
ADDR_BITS, 8, memory depth 2^ADDR_BITS bytes; memory index = A[ADDR_BITS-1:0] (aliases above)
IO_BITS, 4, I/O bank depth 2^IO_BITS registers; index = A[IO_BITS-1:0]
MEM_WAIT, 0, wait states on memory read/write cycles (0..15)
M1_WAIT, 1, extra wait states added on opcode-fetch (M1_n low) cycles (0..15)
IO_WAIT, 1, wait states on I/O read/write cycles (0..15)
INT_VECTOR, 8'hFF, byte driven during interrupt acknowledge

Ports:
CLK_n  in  1  system clock; all logic on posedge CLK_n
RESET_n  in  1  asynchronous, active-low reset
A  in  16  CPU address bus
M1_n  in  1  opcode fetch / interrupt acknowledge
MREQ_n  in  1  memory request
IORQ_n  in  1  I/O request
RD_n  in  1  read strobe
WR_n  in  1  write strobe
RFSH_n  in  1  refresh
d_in  in  8  data from CPU
d_out  out  8  data to CPU
d_oe  out  1  data drive enable; the top level forms the tri-state
WAIT_n  out  1  wait request to CPU
ld_en  in  1  preload write strobe (bench/boot loader)
ld_addr  in  ADDR_BITS  preload address
ld_data  in  8  preload data

Behaviour:
- Reset (async):
  - state=IDLE, WAIT_n=1, d_out=8'h00, d_oe=0, wait counter=0.
  - Memory and I/O contents are not cleared.
- States: IDLE, WAIT, ACCESS, HOLD.
- IDLE → start, on a posedge where any of these is sampled:
  - MEM: MREQ_n=0, RFSH_n=1.
  - IO: IORQ_n=0, M1_n=1.
  - INTA: IORQ_n=0, M1_n=0.
  - MREQ_n=0 with RFSH_n=0 is a refresh: ignored, stays IDLE.
  - If MREQ_n and IORQ_n are both low, MEM wins.
- On start:
  - Latch A and cycle kind.
  - Load count: MEM_WAIT(+M1_WAIT if M1_n=0) for MEM; IO_WAIT for IO/INTA.
  - d_out <= mem[A], io[A], or INT_VECTOR, according to kind.
  - count>0 → WAIT; otherwise → ACCESS.
- WAIT state:
  - WAIT_n=0 (registered) for exactly count clocks, starting the clock after start.
  - Then WAIT_n=1 and → ACCESS.
- ACCESS state:
  - Write occurs on the first posedge with WR_n=0: mem/io[latched addr] <= d_in, exactly once per cycle.
  - INTA never writes.
  - → HOLD.
- HOLD: remains until MREQ_n=1 and IORQ_n=1 are sampled, then → IDLE.
  - A late WR_n (still high on entry to ACCESS) is written when first seen low in HOLD, still once.
- d_oe (combinational): 1 when state≠IDLE and RD_n=0, or when state≠IDLE and kind=INTA; else 0.
  - d_oe is never 1 while WR_n=0.
- Preload port:
  - ld_en writes mem[ld_addr] <= ld_data on posedge.
  - It has priority over a CPU write to the same address in the same clock; the CPU write is dropped.
- Reset mid-cycle: immediate return to IDLE, WAIT_n=1, d_oe=0; no partial write.
- Back-to-back cycles with no idle clock: HOLD exit and start are evaluated in separate clocks. The CPU always deasserts strobes for at least one clock.

Optional Feature:
- Macro BUS_TRACE_EN.
- When defined, adds output ports:
  - trace_valid (1), one-clock pulse on HOLD→IDLE;
  - trace_kind (2): 0 MEM rd, 1 MEM wr, 2 IO rd/wr, 3 INTA;
  - trace_m1 (1);
  - trace_addr (16);
  - trace_data (8): read byte or written byte.
  - Reset value of all trace outputs is 0.
- When undefined, these ports and their logic are absent; behaviour is otherwise identical.

Decomposition:
- Package z80_bus_pkg:
  - cycle-kind enum (MEM, IO, INTA);
  - state enum (IDLE, WAIT, ACCESS, HOLD);
  - trace-kind codes;
  - WAIT_CNT_BITS=4.
- One sub-module, z80_bus_wait_gen: load value, down-counter, registered WAIT_n, done flag.
- Memory and I/O arrays stay in the top.

Test Plan:
- Preload 00:DD 01:21 02:23 03:34 04:21 05:45 06:56, then reset release and run the T800 → CPU executes LD IX,3423h and LD HL,5645h. Fetch addresses 0000–0006 appear in order; d_out matches each byte.
- MEM_WAIT=2, M1_WAIT=1 → WAIT_n low exactly 3 clocks on each M1 fetch and 2 clocks on each MEM read; never low on refresh (RFSH_n=0).
- Memory write: CPU writes 8'hA5 to 0040h with ADDR_BITS=8, then reads 0040h → read returns A5. A single write occurs even when WR_n is held for 3 clocks.
- I/O: OUT (07h),5Ah then IN A,(07h) with IO_WAIT=1 → WAIT_n low 1 clock per I/O cycle; IN returns 5A; memory 07h unchanged.
- INTA: M1_n=0 with IORQ_n=0 and INT_VECTOR=8'hCF → d_oe=1, d_out=CF; no register written.
- Assert RESET_n=0 during WAIT of a write cycle → WAIT_n=1 and d_oe=0 asynchronously; target location keeps its old value. With BUS_TRACE_EN defined, no trace_valid pulse for the aborted cycle.
